// File: rtl/vigenere_pkg.sv
// rtl/vigenere_pkg.sv - shared encodings and helpers for the vigenere stream cipher
package vigenere_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic {
        S_NOKEY = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    // A one-symbol key still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_index_counter.sv
// rtl/key_index_counter.sv - repeating key index with clear > last > wrap priority
module key_index_counter
    import vigenere_pkg::*;
#(
    parameter int  p_secret_length = 6,
    localparam int IW              = idx_width(p_secret_length)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    input  logic          last,
    output logic [IW-1:0] idx
);

    logic at_end;

    assign at_end = (idx == IW'(p_secret_length - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (advance) begin
            if (last || at_end) begin
                idx <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: rtl/vigenere_stream.sv
// rtl/vigenere_stream.sv - byte-serial repeating-key add/subtract cipher with a
// single-entry output register and per-message key index rewind
module vigenere_stream
    import vigenere_pkg::*;
#(
    parameter int  p_secret_length = 6,
    parameter int  p_data_width    = 8,
    localparam int IW              = idx_width(p_secret_length)
) (
    input  logic                                  i_w_clk,
    input  logic                                  i_w_rst_n,
    input  logic [p_secret_length*p_data_width-1:0] i_w_secret,
    input  logic                                  i_w_key_load,
    input  logic                                  i_w_valid,
    output logic                                  o_w_ready,
    input  logic [p_data_width-1:0]               i_w_data,
    input  logic                                  i_w_mode,
    input  logic                                  i_w_last,
    output logic                                  o_r_valid,
    input  logic                                  i_w_ready,
    output logic [p_data_width-1:0]               o_r_data,
    output logic                                  o_r_last,
    output logic [IW-1:0]                         o_r_key_idx
);

    state_t                  state_q, state_d;
    logic [p_data_width-1:0] key_sym [p_secret_length];
    logic [p_data_width-1:0] sel_sym;
    logic [p_data_width-1:0] result;
    logic                    accept;

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            state_q <= S_NOKEY;
        end else begin
            state_q <= state_d;
        end
    end

    // A load cycle never accepts a beat, so the new key applies from the next beat.
    always_comb begin
        state_d   = state_q;
        o_w_ready = 1'b0;
        case (state_q)
            S_NOKEY: begin
                if (i_w_key_load) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                o_w_ready = !i_w_key_load && (!o_r_valid || i_w_ready);
            end
        endcase
    end

    assign accept = i_w_valid && o_w_ready;

    // Symbol 0 sits in the most significant slot, like a packed string literal.
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            for (int i = 0; i < p_secret_length; i++) begin
                key_sym[i] <= '0;
            end
        end else if (i_w_key_load) begin
            for (int i = 0; i < p_secret_length; i++) begin
                key_sym[i] <= i_w_secret[(p_secret_length-1-i)*p_data_width +: p_data_width];
            end
        end
    end

    key_index_counter #(
        .p_secret_length(p_secret_length)
    ) u_key_index_counter (
        .clk    (i_w_clk),
        .rst_n  (i_w_rst_n),
        .clear  (i_w_key_load),
        .advance(accept),
        .last   (i_w_last),
        .idx    (o_r_key_idx)
    );

    always_comb begin
        sel_sym = '0;
        for (int i = 0; i < p_secret_length; i++) begin
            if (o_r_key_idx == IW'(i)) begin
                sel_sym = key_sym[i];
            end
        end
    end

    always_comb begin
        result = i_w_data + sel_sym;
        case (i_w_mode)
            MODE_ENC: result = i_w_data + sel_sym;
            MODE_DEC: result = i_w_data - sel_sym;
            default:  result = i_w_data + sel_sym;
        endcase
    end

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            o_r_valid <= 1'b0;
            o_r_data  <= '0;
            o_r_last  <= 1'b0;
        end else if (accept) begin
            o_r_valid <= 1'b1;
            o_r_data  <= result;
            o_r_last  <= i_w_last;
        end else if (i_w_ready) begin
            o_r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vigenere_stream.sv
// tb/tb_vigenere_stream.sv - self-checking bench for vigenere_stream
module tb_vigenere_stream;

    localparam int L  = 6;
    localparam int W  = 8;
    localparam int IW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [L*W-1:0] secret = '0;
    logic           key_load = 1'b0;
    logic           valid = 1'b0;
    logic [W-1:0]   data = '0;
    logic           mode = 1'b0;
    logic           last = 1'b0;
    logic           dready = 1'b0;
    logic           o_w_ready;
    logic           o_r_valid;
    logic [W-1:0]   o_r_data;
    logic           o_r_last;
    logic [IW-1:0]  o_r_key_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vigenere_stream #(.p_secret_length(L), .p_data_width(W)) dut (
        .i_w_clk     (clk),
        .i_w_rst_n   (rst_n),
        .i_w_secret  (secret),
        .i_w_key_load(key_load),
        .i_w_valid   (valid),
        .o_w_ready   (o_w_ready),
        .i_w_data    (data),
        .i_w_mode    (mode),
        .i_w_last    (last),
        .o_r_valid   (o_r_valid),
        .i_w_ready   (dready),
        .o_r_data    (o_r_data),
        .o_r_last    (o_r_last),
        .o_r_key_idx (o_r_key_idx)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: key as a byte array, index as an integer modulo L.
    logic [W-1:0] m_key [L];
    bit           m_run;
    int           m_idx;
    bit           m_ov;
    logic [W-1:0] m_od;
    bit           m_ol;
    wire          m_ready = m_run && !key_load && (!m_ov || dready);
    wire          m_acc   = valid && m_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 0; m_idx <= 0; m_ov <= 0; m_od <= '0; m_ol <= 0;
            for (int i = 0; i < L; i++) m_key[i] <= '0;
        end else begin
            if (m_acc) begin
                m_od  <= mode ? (data - m_key[m_idx]) : (data + m_key[m_idx]);
                m_ol  <= last;
                m_ov  <= 1;
                m_idx <= (last || m_idx == L - 1) ? 0 : m_idx + 1;
            end else if (dready) begin
                m_ov <= 0;
            end
            if (key_load) begin
                m_run <= 1;
                m_idx <= 0;
                for (int i = 0; i < L; i++) m_key[i] <= secret[(L-1-i)*W +: W];
            end
        end
    end

    logic [8:0] got_q [$];

    always @(negedge clk) begin
        check("ready", o_w_ready, m_ready);
        check("valid", o_r_valid, m_ov);
        check("key_idx", o_r_key_idx, m_idx);
        if (m_ov) begin
            check("data", o_r_data, m_od);
            check("last", o_r_last, m_ol);
        end
        if (o_r_valid && dready) got_q.push_back({o_r_last, o_r_data});
    end

    task automatic load_key(input logic [L*W-1:0] k);
        secret   = k;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic md, input logic ls);
        bit done = 0;
        valid = 1'b1; data = d; mode = md; last = ls;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            done = o_w_ready;
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", 0, 1);
        valid = 1'b0; last = 1'b0;
    endtask

    task automatic expect_bytes(input string name, input logic [8:0] e [8], input int n);
        check({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), got_q[i], e[i]);
        end
        got_q.delete();
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        time t0;
        // Reset state, then a valid beat with no key loaded.
        valid = 1'b1; data = 8'h55;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("nokey_ready", o_w_ready, 0);
        check("nokey_valid", o_r_valid, 0);
        check("nokey_data", o_r_data, 0);
        check("nokey_last", o_r_last, 0);
        check("nokey_idx", o_r_key_idx, 0);
        valid = 1'b0;

        dready = 1'b1;
        load_key("DANILA");
        got_q.delete();
        t0 = $time;
        send("T", 0, 0); send("O", 0, 0); send("P", 0, 0); send("S", 0, 0);
        send("E", 0, 0); send("C", 0, 0); send("R", 0, 0);
        check("throughput_ns", $time - t0, 70);
        drain();
        expect_bytes("enc", '{9'h098, 9'h090, 9'h09E, 9'h09C, 9'h091, 9'h084, 9'h096, 9'h0}, 7);

        load_key("DANILA");
        send(8'h98, 1, 0); send(8'h90, 1, 0); send(8'h9E, 1, 0); send(8'h9C, 1, 0);
        send(8'h91, 1, 0); send(8'h84, 1, 0); send(8'h96, 1, 1);
        drain();
        expect_bytes("dec", '{9'h054, 9'h04F, 9'h050, 9'h053, 9'h045, 9'h043, 9'h152, 9'h0}, 7);

        load_key("DANILA");
        send(8'hF0, 0, 1); send(8'h10, 1, 1);
        drain();
        expect_bytes("wrap", '{9'h134, 9'h1CC, 0, 0, 0, 0, 0, 0}, 2);

        load_key("DANILA");
        send("T", 0, 0); send("O", 0, 0); send("P", 0, 1); send("T", 0, 0);
        drain();
        expect_bytes("rewind", '{9'h098, 9'h090, 9'h19E, 9'h098, 0, 0, 0, 0}, 4);

        // Downstream stall for three cycles mid-stream.
        load_key("DANILA");
        fork
            begin
                send("T", 0, 0); send("O", 0, 0); send("P", 0, 0); send("S", 0, 0);
            end
            begin
                @(posedge clk); #2;
                dready = 1'b0;
                repeat (3) @(posedge clk);
                #2 dready = 1'b1;
            end
        join
        drain();
        expect_bytes("stall", '{9'h098, 9'h090, 9'h09E, 9'h09C, 0, 0, 0, 0}, 4);

        // New key while a beat is pending and the next beat is presented.
        load_key("DANILA");
        dready = 1'b0;
        send("T", 0, 0);
        valid = 1'b1; data = "O"; mode = 0; last = 1'b1;
        secret = "AAAAAA"; key_load = 1'b1;
        @(negedge clk);
        check("load_ready", o_w_ready, 0);
        check("load_pending", o_r_data, 8'h98);
        @(posedge clk); #1;
        key_load = 1'b0;
        dready = 1'b1;
        send("O", 0, 1);
        drain();
        expect_bytes("reload", '{9'h098, 9'h190, 0, 0, 0, 0, 0, 0}, 2);

        // Randomized traffic, with an asynchronous reset partway through.
        for (int c = 0; c < 3000; c++) begin
            valid    = ($urandom_range(0, 3) != 0);
            data     = W'($urandom);
            mode     = $urandom_range(0, 1) == 1;
            last     = ($urandom_range(0, 7) == 0);
            dready   = ($urandom_range(0, 3) != 0);
            key_load = ($urandom_range(0, 60) == 0) || (c == 1510);
            if (key_load) secret = {$urandom, $urandom_range(0, 65535)};
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
            @(posedge clk); #1;
        end
        valid = 1'b0; key_load = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
